// File: rtl/vga_arb_pkg.sv
// Shared types and default sizing for the VGA/CPU memory arbiter.
package vga_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VBURST = 2'd1,
        ST_CPU    = 2'd2
    } arb_state_e;

    localparam int DEF_ADDR_WIDTH = 21;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_BURST_LEN  = 8;
    localparam int DEF_STARVE_MAX = 4;

    // Beat counter only needs to index 0..BURST_LEN-1 because bursts are a power of two.
    function automatic int beat_cnt_width(input int burst_len);
        return (burst_len > 1) ? $clog2(burst_len) : 1;
    endfunction

endpackage

// File: rtl/vga_arb_burst_ctr.sv
// Beat counter, wrapping address incrementer and last-beat detect for one VGA burst.
module vga_arb_burst_ctr
    import vga_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int BURST_LEN  = DEF_BURST_LEN
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  clear_i,
    input  logic                  beat_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [ADDR_WIDTH-1:0] next_addr_o,
    output logic                  last_o
);

    localparam int CNT_W = beat_cnt_width(BURST_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (beat_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Address simply rolls over at the top of memory; bursts need no alignment.
    assign next_addr_o = addr_i + 1'b1;
    assign last_o      = beat_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/vga_mem_arbiter.sv
// Shares a single memory port between a burst-reading VGA client and a CPU.
// Define VGA_ARB_STARVE_GUARD_EN to force a pending CPU access after STARVE_MAX VGA bursts.
module vga_mem_arbiter
    import vga_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BURST_LEN  = DEF_BURST_LEN,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  v_req_i,
    input  logic [ADDR_WIDTH-1:0] v_addr_i,
    output logic                  v_ack_o,
    output logic                  v_valid_o,
    output logic [DATA_WIDTH-1:0] v_data_o,
    output logic                  v_last_o,
    input  logic                  c_read_i,
    input  logic                  c_write_i,
    input  logic [ADDR_WIDTH-1:0] c_addr_i,
    input  logic [DATA_WIDTH-1:0] c_data_i,
    output logic [DATA_WIDTH-1:0] c_data_o,
    output logic                  c_ready_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  mem_ready_i
);

    if (BURST_LEN < 2 || BURST_LEN > 64 || (BURST_LEN & (BURST_LEN - 1)) != 0) begin : g_bad_burst_len
        $error("vga_mem_arbiter: BURST_LEN must be a power of two in 2..64");
    end
    if (STARVE_MAX < 1) begin : g_bad_starve_max
        $error("vga_mem_arbiter: STARVE_MAX must be at least 1");
    end

    arb_state_e            state_q, state_d;
    logic                  v_ack_q, v_ack_d;
    logic                  v_valid_q, v_valid_d;
    logic                  v_last_q, v_last_d;
    logic [DATA_WIDTH-1:0] v_data_q, v_data_d;
    logic                  c_ready_q, c_ready_d;
    logic [DATA_WIDTH-1:0] c_data_q, c_data_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;

    logic                  cpu_pending;
    logic                  force_cpu;
    logic                  grant_cpu;
    logic                  grant_vga;
    logic                  beat_accept;
    logic                  beat_last;
    logic [ADDR_WIDTH-1:0] next_addr;

    // A simultaneous read and write is treated as a write.
    assign cpu_pending = c_read_i | c_write_i;
    assign grant_cpu   = (state_q == ST_IDLE) && cpu_pending && (force_cpu || !v_req_i);
    assign grant_vga   = (state_q == ST_IDLE) && v_req_i && !grant_cpu;
    assign beat_accept = (state_q == ST_VBURST) && mem_ready_i;

    vga_arb_burst_ctr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BURST_LEN  (BURST_LEN)
    ) u_burst_ctr (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .clear_i     (grant_vga),
        .beat_i      (beat_accept),
        .addr_i      (mem_addr_q),
        .next_addr_o (next_addr),
        .last_o      (beat_last)
    );

`ifdef VGA_ARB_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve_q, starve_d;

    assign force_cpu = (starve_q == STARVE_LIMIT);

    // Only VGA grants that jump ahead of a waiting CPU count towards starvation.
    always_comb begin
        starve_d = starve_q;
        if (grant_cpu) begin
            starve_d = '0;
        end else if (grant_vga && cpu_pending && (starve_q != STARVE_LIMIT)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_cpu = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        v_ack_d     = 1'b0;
        v_valid_d   = 1'b0;
        v_last_d    = 1'b0;
        v_data_d    = v_data_q;
        c_ready_d   = 1'b0;
        c_data_d    = c_data_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_cpu) begin
                    state_d     = ST_CPU;
                    mem_write_d = c_write_i;
                    mem_read_d  = !c_write_i;
                    mem_addr_d  = c_addr_i;
                    mem_data_d  = c_write_i ? c_data_i : '0;
                end else if (grant_vga) begin
                    state_d     = ST_VBURST;
                    v_ack_d     = 1'b1;
                    mem_read_d  = 1'b1;
                    mem_write_d = 1'b0;
                    mem_addr_d  = v_addr_i;
                    mem_data_d  = '0;
                end
            end

            ST_VBURST: begin
                if (beat_accept) begin
                    v_valid_d  = 1'b1;
                    v_data_d   = mem_data_i;
                    mem_addr_d = next_addr;
                    if (beat_last) begin
                        v_last_d   = 1'b1;
                        mem_read_d = 1'b0;
                        state_d    = ST_IDLE;
                    end
                end
            end

            ST_CPU: begin
                if (mem_ready_i) begin
                    c_ready_d   = 1'b1;
                    if (!mem_write_q) begin
                        c_data_d = mem_data_i;
                    end
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    mem_data_d  = '0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                mem_data_d  = '0;
            end
        endcase
    end

    // Reset drops any transfer in flight without issuing its completion pulse.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            v_ack_q     <= 1'b0;
            v_valid_q   <= 1'b0;
            v_last_q    <= 1'b0;
            v_data_q    <= '0;
            c_ready_q   <= 1'b0;
            c_data_q    <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            v_ack_q     <= v_ack_d;
            v_valid_q   <= v_valid_d;
            v_last_q    <= v_last_d;
            v_data_q    <= v_data_d;
            c_ready_q   <= c_ready_d;
            c_data_q    <= c_data_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
        end
    end

    assign v_ack_o     = v_ack_q;
    assign v_valid_o   = v_valid_q;
    assign v_last_o    = v_last_q;
    assign v_data_o    = v_data_q;
    assign c_ready_o   = c_ready_q;
    assign c_data_o    = c_data_q;
    assign mem_read_o  = mem_read_q;
    assign mem_write_o = mem_write_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_data_o  = mem_data_q;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Self-checking bench for vga_mem_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level reference model of the arbiter.
module tb_vga_mem_arbiter;

    localparam int AW = 21;
    localparam int DW = 32;
    localparam int BL = 8;
    localparam int SM = 4;

    logic          clock_i = 1'b0;
    logic          reset_i;
    logic          v_req_i;
    logic [AW-1:0] v_addr_i;
    logic          v_ack_o;
    logic          v_valid_o;
    logic [DW-1:0] v_data_o;
    logic          v_last_o;
    logic          c_read_i;
    logic          c_write_i;
    logic [AW-1:0] c_addr_i;
    logic [DW-1:0] c_data_i;
    logic [DW-1:0] c_data_o;
    logic          c_ready_o;
    logic          mem_read_o;
    logic          mem_write_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_o;
    logic [DW-1:0] mem_data_i;
    logic          mem_ready_i;

    always #5 clock_i = ~clock_i;

    vga_mem_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL),
        .STARVE_MAX (SM)
    ) dut (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .v_req_i     (v_req_i),
        .v_addr_i    (v_addr_i),
        .v_ack_o     (v_ack_o),
        .v_valid_o   (v_valid_o),
        .v_data_o    (v_data_o),
        .v_last_o    (v_last_o),
        .c_read_i    (c_read_i),
        .c_write_i   (c_write_i),
        .c_addr_i    (c_addr_i),
        .c_data_i    (c_data_i),
        .c_data_o    (c_data_o),
        .c_ready_o   (c_ready_o),
        .mem_read_o  (mem_read_o),
        .mem_write_o (mem_write_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_data_i  (mem_data_i),
        .mem_ready_i (mem_ready_i)
    );

    // Memory contents are a fixed function of the address, so read data is predictable.
    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        return {a[10:0], a} ^ 32'hA5C3_0F1E;
    endfunction

    assign mem_data_i = memf(mem_addr_o);

    int vectors     = 0;
    int miscompares = 0;
    int cycle       = 0;

    // Reference model: expected outputs after the next clock edge.
    bit            e_ack, e_valid, e_last, e_cready, e_mrd, e_mwr;
    logic [AW-1:0] e_maddr;
    logic [DW-1:0] e_vdata, e_cdata, e_mdata;
    bit            m_in_vga, m_in_cpu;
    int            m_beats_left;
    int            m_starve;

    // Results of the most recent runBurst call.
    int            rb_acks, rb_beats, rb_last_at, rb_first_ack;
    logic [AW-1:0] beat_addrs[$];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    function automatic bit starveForced();
`ifdef VGA_ARB_STARVE_GUARD_EN
        return m_starve >= SM;
`else
        return 1'b0;
`endif
    endfunction

    // Transaction-level view: the arbiter is free, streaming a burst, or serving one CPU access.
    task automatic modelStep();
        bit cpu_req;
        cpu_req  = c_read_i | c_write_i;
        e_ack    = 1'b0;
        e_valid  = 1'b0;
        e_last   = 1'b0;
        e_cready = 1'b0;
        if (reset_i) begin
            e_vdata = '0; e_cdata = '0; e_mdata = '0; e_maddr = '0;
            e_mrd = 1'b0; e_mwr = 1'b0;
            m_in_vga = 1'b0; m_in_cpu = 1'b0; m_beats_left = 0; m_starve = 0;
        end else if (m_in_vga) begin
            if (mem_ready_i) begin
                e_valid      = 1'b1;
                e_vdata      = memf(e_maddr);
                e_maddr      = AW'((int'(e_maddr) + 1) % (1 << AW));
                m_beats_left = m_beats_left - 1;
                if (m_beats_left == 0) begin
                    e_last   = 1'b1;
                    e_mrd    = 1'b0;
                    m_in_vga = 1'b0;
                end
            end
        end else if (m_in_cpu) begin
            if (mem_ready_i) begin
                e_cready = 1'b1;
                if (e_mrd) e_cdata = memf(e_maddr);
                e_mrd    = 1'b0;
                e_mwr    = 1'b0;
                e_mdata  = '0;
                m_in_cpu = 1'b0;
            end
        end else if (cpu_req && (starveForced() || !v_req_i)) begin
            m_in_cpu = 1'b1;
            e_mwr    = c_write_i;
            e_mrd    = !c_write_i;
            e_maddr  = c_addr_i;
            e_mdata  = c_write_i ? c_data_i : '0;
            m_starve = 0;
        end else if (v_req_i) begin
            m_in_vga     = 1'b1;
            e_ack        = 1'b1;
            e_mrd        = 1'b1;
            e_mwr        = 1'b0;
            e_maddr      = v_addr_i;
            e_mdata      = '0;
            m_beats_left = BL;
            if (cpu_req) m_starve = m_starve + 1;
        end
    endtask

    task automatic checkAll();
        checkOutput("v_ack",     64'(v_ack_o),     64'(e_ack));
        checkOutput("v_valid",   64'(v_valid_o),   64'(e_valid));
        checkOutput("v_last",    64'(v_last_o),    64'(e_last));
        checkOutput("c_ready",   64'(c_ready_o),   64'(e_cready));
        checkOutput("c_data",    64'(c_data_o),    64'(e_cdata));
        checkOutput("mem_read",  64'(mem_read_o),  64'(e_mrd));
        checkOutput("mem_write", 64'(mem_write_o), 64'(e_mwr));
        checkOutput("mem_data",  64'(mem_data_o),  64'(e_mdata));
        if (e_mrd || e_mwr) checkOutput("mem_addr", 64'(mem_addr_o), 64'(e_maddr));
        if (e_valid)        checkOutput("v_data",   64'(v_data_o),   64'(e_vdata));
    endtask

    // Inputs are already set; predict, clock once, then compare one time unit after the edge.
    task automatic applyStimulus();
        modelStep();
        @(posedge clock_i);
        #1;
        cycle++;
        checkAll();
    endtask

    task automatic setIdleInputs();
        reset_i     = 1'b0;
        v_req_i     = 1'b0;
        v_addr_i    = '0;
        c_read_i    = 1'b0;
        c_write_i   = 1'b0;
        c_addr_i    = '0;
        c_data_i    = '0;
        mem_ready_i = 1'b0;
    endtask

    task automatic drain(input int n);
        setIdleInputs();
        mem_ready_i = 1'b1;
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    // One VGA burst with memory always ready; request dropped once the model says it was granted.
    task automatic runBurst(input logic [AW-1:0] start, input int n_cycles);
        setIdleInputs();
        v_req_i      = 1'b1;
        v_addr_i     = start;
        mem_ready_i  = 1'b1;
        rb_acks      = 0;
        rb_beats     = 0;
        rb_last_at   = 0;
        rb_first_ack = 0;
        beat_addrs.delete();
        for (int i = 0; i < n_cycles; i++) begin
            applyStimulus();
            if (e_ack) v_req_i = 1'b0;
            if (v_ack_o) begin
                rb_acks++;
                if (rb_first_ack == 0) rb_first_ack = i + 1;
            end
            if (mem_read_o) beat_addrs.push_back(mem_addr_o);
            if (v_valid_o) begin
                rb_beats++;
                if (v_last_o) rb_last_at = rb_beats;
            end
        end
    endtask

    initial begin
        int wr_cycles, crdy, last_cyc, crdy_cyc, acks, cgrant_acks, beats, last_seen;

        // Reset state
        setIdleInputs();
        reset_i = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("reset_v_data",   64'(v_data_o),   64'(0));
        checkOutput("reset_c_data",   64'(c_data_o),   64'(0));
        checkOutput("reset_mem_addr", 64'(mem_addr_o), 64'(0));

        // Basic burst from 0x100
        runBurst(21'h100, 14);
        checkOutput("burst_acks",     64'(rb_acks),      64'(1));
        checkOutput("burst_first_ack",64'(rb_first_ack), 64'(1));
        checkOutput("burst_beats",    64'(rb_beats),     64'(BL));
        checkOutput("burst_last_beat",64'(rb_last_at),   64'(BL));
        checkOutput("burst_addr_cnt", 64'(beat_addrs.size()), 64'(BL));
        for (int k = 0; k < beat_addrs.size(); k++)
            checkOutput("burst_addr", 64'(beat_addrs[k]), 64'(32'h100 + k));

        // CPU write with memory ready in the third command cycle
        setIdleInputs();
        c_write_i = 1'b1;
        c_addr_i  = 21'h20;
        c_data_i  = 32'hDEADBEEF;
        wr_cycles = 0;
        crdy      = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus();
            if (mem_write_o) begin
                wr_cycles++;
                checkOutput("cpu_wr_data", 64'(mem_data_o), 64'(32'hDEADBEEF));
            end
            if (c_ready_o) crdy++;
            if (m_in_cpu) c_write_i = 1'b0;
            mem_ready_i = (wr_cycles == 3);
        end
        checkOutput("cpu_wr_hold",   64'(wr_cycles), 64'(3));
        checkOutput("cpu_wr_pulses", 64'(crdy),      64'(1));

        // Simultaneous VGA and CPU read: VGA first, CPU right after the burst
        setIdleInputs();
        v_req_i     = 1'b1;
        v_addr_i    = 21'h300;
        c_read_i    = 1'b1;
        c_addr_i    = 21'h44;
        mem_ready_i = 1'b1;
        last_cyc    = -1;
        crdy_cyc    = -1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus();
            if (e_ack) v_req_i = 1'b0;
            if (e_cready) c_read_i = 1'b0;
            if (v_last_o && last_cyc < 0) last_cyc = cycle;
            if (c_ready_o && crdy_cyc < 0) crdy_cyc = cycle;
        end
        checkOutput("vga_before_cpu", 64'(last_cyc >= 0 && crdy_cyc > last_cyc), 64'(1));
        checkOutput("cpu_after_last", 64'(crdy_cyc - last_cyc), 64'(2));
        checkOutput("cpu_read_data",  64'(c_data_o), 64'(memf(21'h44)));

        // Burst wrapping past the top of the address space
        runBurst(21'h1FFFFE, 14);
        checkOutput("wrap_addr_cnt", 64'(beat_addrs.size()), 64'(BL));
        for (int k = 0; k < beat_addrs.size(); k++)
            checkOutput("wrap_addr", 64'(beat_addrs[k]), 64'((32'h1FFFFE + k) % (1 << AW)));

        // VGA hammering while a CPU read waits
        setIdleInputs();
        v_req_i     = 1'b1;
        v_addr_i    = 21'h500;
        c_read_i    = 1'b1;
        c_addr_i    = 21'h66;
        mem_ready_i = 1'b1;
        acks        = 0;
        cgrant_acks = -1;
        for (int i = 0; i < 80 && cgrant_acks < 0; i++) begin
            applyStimulus();
            if (v_ack_o) acks++;
            if (c_ready_o) cgrant_acks = acks;
            if (e_cready) c_read_i = 1'b0;
        end
`ifdef VGA_ARB_STARVE_GUARD_EN
        checkOutput("starve_bursts", 64'(cgrant_acks), 64'(SM));
`else
        checkOutput("strict_prio_cpu_blocked", 64'(cgrant_acks), 64'(-1));
`endif
        drain(12);

        // Reset in the middle of a burst, then a fresh burst
        setIdleInputs();
        v_req_i     = 1'b1;
        v_addr_i    = 21'h700;
        mem_ready_i = 1'b1;
        beats       = 0;
        last_seen   = 0;
        for (int i = 0; i < 20 && beats < 3; i++) begin
            applyStimulus();
            if (e_ack) v_req_i = 1'b0;
            if (v_valid_o) beats++;
            if (v_last_o) last_seen++;
        end
        reset_i  = 1'b1;
        v_req_i  = 1'b1;
        v_addr_i = 21'h7F0;
        applyStimulus();
        checkOutput("rst_mid_v_valid",  64'(v_valid_o),  64'(0));
        checkOutput("rst_mid_mem_read", 64'(mem_read_o), 64'(0));
        checkOutput("rst_mid_no_last",  64'(last_seen + int'(v_last_o)), 64'(0));
        runBurst(21'h7F0, 14);
        checkOutput("post_rst_first_ack", 64'(rb_first_ack), 64'(1));
        checkOutput("post_rst_beats",     64'(rb_beats),     64'(BL));
        checkOutput("post_rst_last",      64'(rb_last_at),   64'(BL));

        // Randomized traffic
        setIdleInputs();
        for (int i = 0; i < 1500; i++) begin
            reset_i = ($urandom_range(0, 199) == 0);
            if (!v_req_i && $urandom_range(0, 3) == 0) begin
                v_req_i  = 1'b1;
                v_addr_i = AW'($urandom);
            end
            if (!(c_read_i || c_write_i)) begin
                if ($urandom_range(0, 3) == 0) begin
                    c_read_i  = 1'($urandom);
                    c_write_i = 1'($urandom);
                    c_addr_i  = AW'($urandom);
                    c_data_i  = $urandom;
                end
            end else if (!m_in_cpu && $urandom_range(0, 15) == 0) begin
                c_read_i  = 1'b0;
                c_write_i = 1'b0;
            end
            mem_ready_i = ($urandom_range(0, 99) < 65);
            applyStimulus();
            if (e_ack) v_req_i = 1'b0;
            if (e_cready) begin
                c_read_i  = 1'b0;
                c_write_i = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, cycle %0d", cycle);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
